// File: rtl/seg_display_mux.sv
// seg_display_mux: samples a 4-bit count and scans ones / tens / blank / hex digits onto
// a 4-digit common-anode seven-segment display, with inter-digit blanking and frame-atomic updates.
module seg_display_mux #(
    parameter logic [15:0] REFRESH_DIV = 16'd50000,
    parameter logic [15:0] BLANK_CYC   = 16'd1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] a,
    output logic [6:0] seg,
    output logic [3:0] an
);
    function automatic logic [6:0] f_glyph(input logic [3:0] v);
        case (v)
            4'h0: f_glyph = 7'b1000000;
            4'h1: f_glyph = 7'b1111001;
            4'h2: f_glyph = 7'b0100100;
            4'h3: f_glyph = 7'b0110000;
            4'h4: f_glyph = 7'b0011001;
            4'h5: f_glyph = 7'b0010010;
            4'h6: f_glyph = 7'b0000010;
            4'h7: f_glyph = 7'b1111000;
            4'h8: f_glyph = 7'b0000000;
            4'h9: f_glyph = 7'b0010000;
            4'hA: f_glyph = 7'b0001000;
            4'hB: f_glyph = 7'b0000011;
            4'hC: f_glyph = 7'b1000110;
            4'hD: f_glyph = 7'b0100001;
            4'hE: f_glyph = 7'b0000110;
            default: f_glyph = 7'b0001110;
        endcase
    endfunction

    logic [3:0]  r_a_q, r_disp;
    logic [15:0] r_cnt;
    logic [1:0]  r_idx;
    logic        w_last, w_blank, w_tens;
    logic [3:0]  w_ones, w_an;
    logic [6:0]  w_seg;

    assign w_last  = r_cnt == REFRESH_DIV - 16'd1;
    assign w_blank = r_cnt < BLANK_CYC;
    assign w_tens  = r_disp >= 4'd10;
    assign w_ones  = w_tens ? r_disp - 4'd10 : r_disp;
    assign w_an    = w_blank ? 4'b1111 : ~(4'b0001 << r_idx);
    // Slot 2 keeps its anode driven but never lights a segment.
    assign w_seg   = w_blank       ? 7'h7F :
                     r_idx == 2'd0 ? f_glyph(w_ones) :
                     r_idx == 2'd1 ? (w_tens ? 7'b1111001 : 7'h7F) :
                     r_idx == 2'd2 ? 7'h7F : f_glyph(r_disp);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a_q  <= '0;
            r_disp <= '0;
            r_cnt  <= '0;
            r_idx  <= '0;
            seg    <= 7'h7F;
            an     <= 4'hF;
        end else begin
            r_a_q <= a;
            r_cnt <= w_last ? '0 : r_cnt + 16'd1;
            if (w_last) r_idx <= r_idx + 2'd1;
            if (w_last && r_idx == 2'd3) r_disp <= r_a_q;
            seg <= w_seg;
            an  <= w_an;
        end
    end
endmodule
